// File: rtl/issue_controller_pkg.sv
// Shared types for the issue controller: decoded ops, EX control bus, ALU/MDU encodings.
// FSM state codes live here too so decode and sequencing agree on them.
package issue_controller_pkg;

  localparam int ALU_OP_WIDTH = 4;
  localparam int MDU_OP_WIDTH = 3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd9;

  localparam logic [MDU_OP_WIDTH-1:0] MD_MUL    = 3'd0;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MULH   = 3'd1;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MULHSU = 3'd2;
  localparam logic [MDU_OP_WIDTH-1:0] MD_MULHU  = 3'd3;
  localparam logic [MDU_OP_WIDTH-1:0] MD_DIV    = 3'd4;
  localparam logic [MDU_OP_WIDTH-1:0] MD_DIVU   = 3'd5;
  localparam logic [MDU_OP_WIDTH-1:0] MD_REM    = 3'd6;
  localparam logic [MDU_OP_WIDTH-1:0] MD_REMU   = 3'd7;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MEM_REQ = 2'd1;
  localparam logic [1:0] ST_MEM_RSP = 2'd2;
  localparam logic [1:0] ST_MD_BUSY = 2'd3;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
    OP_LUI, OP_AUIPC, OP_LW, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
    OP_JAL, OP_JALR,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_INVALID
  } decoded_op;

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    imm;
    logic                    stype;
    logic                    upper;
    logic                    lui_shift;
    logic                    pc_ula;
    logic                    load;
    logic                    store;
    logic                    branch;
    logic                    brn_inv;
    logic                    jal;
    logic                    jalr;
    logic [MDU_OP_WIDTH-1:0] md_op;
  } ctrl_bus_t;

endpackage

// File: rtl/issue_controller_controller.sv
// Combinational decode of a decoded_op into the EX control bus.
// MDU ops decode only when RISCV_M_CORE_EN is defined; otherwise they are illegal.
module controller
  import issue_controller_pkg::*;
(
  input  decoded_op i_op,
  output ctrl_bus_t o_ctrl,
  output logic      o_wen,
  output logic      o_legal,
  output logic      o_is_md,
  output logic      o_is_div
);

  always_comb begin
    o_ctrl   = '0;
    o_wen    = 1'b0;
    o_legal  = 1'b1;
    o_is_md  = 1'b0;
    o_is_div = 1'b0;
    unique case (i_op)
      OP_ADD:  begin o_ctrl.alu_op = ALU_ADD;  o_wen = 1'b1; end
      OP_SUB:  begin o_ctrl.alu_op = ALU_SUB;  o_wen = 1'b1; end
      OP_AND:  begin o_ctrl.alu_op = ALU_AND;  o_wen = 1'b1; end
      OP_OR:   begin o_ctrl.alu_op = ALU_OR;   o_wen = 1'b1; end
      OP_XOR:  begin o_ctrl.alu_op = ALU_XOR;  o_wen = 1'b1; end
      OP_SLL:  begin o_ctrl.alu_op = ALU_SLL;  o_wen = 1'b1; end
      OP_SRL:  begin o_ctrl.alu_op = ALU_SRL;  o_wen = 1'b1; end
      OP_SRA:  begin o_ctrl.alu_op = ALU_SRA;  o_wen = 1'b1; end
      OP_SLT:  begin o_ctrl.alu_op = ALU_SLT;  o_wen = 1'b1; end
      OP_SLTU: begin o_ctrl.alu_op = ALU_SLTU; o_wen = 1'b1; end
      OP_ADDI: begin o_ctrl.alu_op = ALU_ADD; o_ctrl.imm = 1'b1; o_wen = 1'b1; end
      OP_ANDI: begin o_ctrl.alu_op = ALU_AND; o_ctrl.imm = 1'b1; o_wen = 1'b1; end
      OP_ORI:  begin o_ctrl.alu_op = ALU_OR;  o_ctrl.imm = 1'b1; o_wen = 1'b1; end
      OP_XORI: begin o_ctrl.alu_op = ALU_XOR; o_ctrl.imm = 1'b1; o_wen = 1'b1; end
      OP_SLTI: begin o_ctrl.alu_op = ALU_SLT; o_ctrl.imm = 1'b1; o_wen = 1'b1; end
      OP_LUI: begin
        o_ctrl.imm = 1'b1; o_ctrl.upper = 1'b1;
        o_ctrl.lui_shift = 1'b1; o_wen = 1'b1;
      end
      OP_AUIPC: begin
        o_ctrl.imm = 1'b1; o_ctrl.upper = 1'b1;
        o_ctrl.pc_ula = 1'b1; o_wen = 1'b1;
      end
      OP_LW: begin o_ctrl.imm = 1'b1; o_ctrl.load = 1'b1; o_wen = 1'b1; end
      OP_SW: begin
        o_ctrl.imm = 1'b1; o_ctrl.stype = 1'b1; o_ctrl.store = 1'b1;
      end
      // Branch compare reuses SUB (equality) and SLT; brn_inv flips the sense.
      OP_BEQ: begin o_ctrl.alu_op = ALU_SUB; o_ctrl.branch = 1'b1; end
      OP_BNE: begin
        o_ctrl.alu_op = ALU_SUB; o_ctrl.branch = 1'b1; o_ctrl.brn_inv = 1'b1;
      end
      OP_BLT: begin o_ctrl.alu_op = ALU_SLT; o_ctrl.branch = 1'b1; end
      OP_BGE: begin
        o_ctrl.alu_op = ALU_SLT; o_ctrl.branch = 1'b1; o_ctrl.brn_inv = 1'b1;
      end
      OP_JAL:  begin o_ctrl.jal = 1'b1; o_ctrl.pc_ula = 1'b1; o_wen = 1'b1; end
      OP_JALR: begin o_ctrl.jalr = 1'b1; o_ctrl.imm = 1'b1; o_wen = 1'b1; end
`ifdef RISCV_M_CORE_EN
      OP_MUL:    begin o_ctrl.md_op = MD_MUL;    o_is_md = 1'b1; o_wen = 1'b1; end
      OP_MULH:   begin o_ctrl.md_op = MD_MULH;   o_is_md = 1'b1; o_wen = 1'b1; end
      OP_MULHSU: begin o_ctrl.md_op = MD_MULHSU; o_is_md = 1'b1; o_wen = 1'b1; end
      OP_MULHU:  begin o_ctrl.md_op = MD_MULHU;  o_is_md = 1'b1; o_wen = 1'b1; end
      OP_DIV: begin
        o_ctrl.md_op = MD_DIV; o_is_md = 1'b1; o_is_div = 1'b1; o_wen = 1'b1;
      end
      OP_DIVU: begin
        o_ctrl.md_op = MD_DIVU; o_is_md = 1'b1; o_is_div = 1'b1; o_wen = 1'b1;
      end
      OP_REM: begin
        o_ctrl.md_op = MD_REM; o_is_md = 1'b1; o_is_div = 1'b1; o_wen = 1'b1;
      end
      OP_REMU: begin
        o_ctrl.md_op = MD_REMU; o_is_md = 1'b1; o_is_div = 1'b1; o_wen = 1'b1;
      end
`endif
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/issue_controller.sv
// Issue stage: EX register, RUN/MEM_REQ/MEM_RSP/MD_BUSY FSM and MDU occupancy counter.
// Define RISCV_M_CORE_EN to enable MUL/DIV issue; otherwise those ops raise illegal.
module issue_controller
  import issue_controller_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      instr_valid_i,
  input  decoded_op decoded_op_i,
  output logic      instr_ready_o,
  output logic      ex_valid_o,
  output ctrl_bus_t ex_ctrl_o,
  output logic      wb_en_o,
  input  logic      branch_taken_i,
  output logic      flush_o,
  output logic      data_req_o,
  output logic      data_we_o,
  input  logic      data_gnt_i,
  input  logic      data_rvalid_i,
  output logic      mdu_start_o,
  output logic      illegal_instr_o
);

  ctrl_bus_t  w_ctrl;
  logic       w_wen, w_legal, w_is_md, w_is_div;
  logic       w_issue, w_flush, w_wb, w_run;
  logic [1:0] r_state;
  logic       r_ex_valid, r_wen, r_ill;
  ctrl_bus_t  r_ctrl;

  controller u_controller (
    .i_op     (decoded_op_i),
    .o_ctrl   (w_ctrl),
    .o_wen    (w_wen),
    .o_legal  (w_legal),
    .o_is_md  (w_is_md),
    .o_is_div (w_is_div)
  );

  assign w_run   = (r_state == ST_RUN);
  assign w_flush = w_run & r_ex_valid & branch_taken_i
                 & (r_ctrl.branch | r_ctrl.jal | r_ctrl.jalr);
  assign w_issue = instr_valid_i & w_run & ~w_flush;

`ifdef RISCV_M_CORE_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_start;
  logic          w_cnt_last;

  assign w_cnt_last = (r_cnt == CW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_issue & w_is_md;
      if (w_issue & w_is_md)
        r_cnt <= w_is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      else if (r_state == ST_MD_BUSY && !w_cnt_last)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  assign mdu_start_o = r_start;
`else
  logic [31:0] w_cfg_unused;
  assign w_cfg_unused = 32'(MUL_CYCLES + DIV_CYCLES) ^ {30'd0, w_is_md, w_is_div};
  assign mdu_start_o  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_RUN;
      r_ex_valid <= 1'b0;
      r_ctrl     <= '0;
      r_wen      <= 1'b0;
      r_ill      <= 1'b0;
    end else begin
      r_ill <= w_issue & ~w_legal;
      case (r_state)
        ST_RUN: begin
          r_ex_valid <= w_issue & w_legal;
          if (w_issue) begin
            r_ctrl <= w_ctrl;
            r_wen  <= w_wen;
          end
          if (w_issue & w_legal & (w_ctrl.load | w_ctrl.store))
            r_state <= ST_MEM_REQ;
`ifdef RISCV_M_CORE_EN
          if (w_issue & w_legal & w_is_md)
            r_state <= ST_MD_BUSY;
`endif
        end
        ST_MEM_REQ: begin
          if (data_gnt_i) begin
            r_state    <= r_ctrl.store ? ST_RUN : ST_MEM_RSP;
            r_ex_valid <= ~r_ctrl.store;
          end
        end
        ST_MEM_RSP: begin
          if (data_rvalid_i) begin
            r_state    <= ST_RUN;
            r_ex_valid <= 1'b0;
          end
        end
`ifdef RISCV_M_CORE_EN
        ST_MD_BUSY: begin
          if (w_cnt_last) begin
            r_state    <= ST_RUN;
            r_ex_valid <= 1'b0;
          end
        end
`endif
        default: begin
          r_state    <= ST_RUN;
          r_ex_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_wb = 1'b0;
    case (r_state)
      ST_RUN:     w_wb = r_ex_valid & r_wen;
      ST_MEM_RSP: w_wb = data_rvalid_i;
`ifdef RISCV_M_CORE_EN
      ST_MD_BUSY: w_wb = w_cnt_last;
`endif
      default:    w_wb = 1'b0;
    endcase
  end

  assign instr_ready_o   = w_run & ~w_flush;
  assign ex_valid_o      = r_ex_valid;
  assign ex_ctrl_o       = r_ctrl;
  assign wb_en_o         = w_wb;
  assign flush_o         = w_flush;
  assign data_req_o      = (r_state == ST_MEM_REQ);
  assign data_we_o       = (r_state == ST_MEM_REQ) & r_ctrl.store;
  assign illegal_instr_o = r_ill;

endmodule

// File: tb/tb_issue_controller.sv
// Directed-vector bench for issue_controller with hand-computed expectations.
// MDU sequences run only when RISCV_M_CORE_EN is defined; else MUL must trap.
module tb_issue_controller;
  import issue_controller_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_i;
  logic      instr_valid_i;
  decoded_op decoded_op_i;
  logic      instr_ready_o, ex_valid_o, wb_en_o;
  ctrl_bus_t ex_ctrl_o;
  logic      branch_taken_i, flush_o;
  logic      data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic      mdu_start_o, illegal_instr_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  issue_controller dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .instr_valid_i   (instr_valid_i),
    .decoded_op_i    (decoded_op_i),
    .instr_ready_o   (instr_ready_o),
    .ex_valid_o      (ex_valid_o),
    .ex_ctrl_o       (ex_ctrl_o),
    .wb_en_o         (wb_en_o),
    .branch_taken_i  (branch_taken_i),
    .flush_o         (flush_o),
    .data_req_o      (data_req_o),
    .data_we_o       (data_we_o),
    .data_gnt_i      (data_gnt_i),
    .data_rvalid_i   (data_rvalid_i),
    .mdu_start_o     (mdu_start_o),
    .illegal_instr_o (illegal_instr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, then drive this cycle's inputs.
  task automatic cyc(input logic v, input decoded_op op, input logic gnt,
                     input logic rv, input logic tk);
    @(posedge clk_i);
    #1;
    instr_valid_i  = v;
    decoded_op_i   = op;
    data_gnt_i     = gnt;
    data_rvalid_i  = rv;
    branch_taken_i = tk;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, OP_ADD, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef RISCV_M_CORE_EN
  // Issue DIV, then walk k cycles of MD_BUSY (k < 32 means stop early).
  task automatic run_div(input string tag, input int k);
    cyc(1'b1, OP_DIV, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= k; i++) begin
      idle();
      check({tag, " rdy"}, 32'(instr_ready_o), 32'd0);
      check({tag, " start"}, 32'(mdu_start_o), 32'(i == 1));
      check({tag, " wb"}, 32'(wb_en_o), 32'(i == 32));
    end
  endtask
`endif

  initial begin
    rst_i          = 1'b1;
    instr_valid_i  = 1'b0;
    decoded_op_i   = OP_ADD;
    data_gnt_i     = 1'b0;
    data_rvalid_i  = 1'b0;
    branch_taken_i = 1'b0;
    #3;
    check("rst rdy", 32'(instr_ready_o), 32'd1);
    check("rst exv", 32'(ex_valid_o), 32'd0);
    check("rst ctrl", 32'(ex_ctrl_o), 32'd0);
    check("rst req", 32'(data_req_o), 32'd0);
    check("rst wb", 32'(wb_en_o), 32'd0);
    check("rst ill", 32'(illegal_instr_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // ADD then ADDI back to back
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("add rdy", 32'(instr_ready_o), 32'd1);
    check("add exv0", 32'(ex_valid_o), 32'd0);
    cyc(1'b1, OP_ADDI, 1'b0, 1'b0, 1'b0);
    check("addi rdy", 32'(instr_ready_o), 32'd1);
    check("add exv", 32'(ex_valid_o), 32'd1);
    check("add wb", 32'(wb_en_o), 32'd1);
    check("add alu", 32'(ex_ctrl_o.alu_op), 32'(ALU_ADD));
    check("add imm", 32'(ex_ctrl_o.imm), 32'd0);
    idle();
    check("addi exv", 32'(ex_valid_o), 32'd1);
    check("addi wb", 32'(wb_en_o), 32'd1);
    check("addi imm", 32'(ex_ctrl_o.imm), 32'd1);
    idle();
    check("idle exv", 32'(ex_valid_o), 32'd0);
    check("idle wb", 32'(wb_en_o), 32'd0);

    // LW: gnt 3 cycles after req, rvalid 2 cycles after gnt
    cyc(1'b1, OP_LW, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("lw req1", 32'(data_req_o), 32'd1);
    check("lw we", 32'(data_we_o), 32'd0);
    check("lw rdy1", 32'(instr_ready_o), 32'd0);
    check("lw ld", 32'(ex_ctrl_o.load), 32'd1);
    cyc(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0);
    check("lw req2", 32'(data_req_o), 32'd1);
    check("lw rv ign", 32'(wb_en_o), 32'd0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("lw req3", 32'(data_req_o), 32'd1);
    cyc(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0);
    check("lw req4", 32'(data_req_o), 32'd1);
    check("lw wb4", 32'(wb_en_o), 32'd0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("lw req5", 32'(data_req_o), 32'd0);
    check("lw wait", 32'(wb_en_o), 32'd0);
    check("lw rdy5", 32'(instr_ready_o), 32'd0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0);
    check("lw wb", 32'(wb_en_o), 32'd1);
    check("lw rdy6", 32'(instr_ready_o), 32'd0);
    idle();
    check("lw rdy7", 32'(instr_ready_o), 32'd1);
    check("lw exv7", 32'(ex_valid_o), 32'd0);
    check("lw wb7", 32'(wb_en_o), 32'd0);

    // SW granted immediately, never writes back
    cyc(1'b1, OP_SW, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, OP_ADD, 1'b1, 1'b0, 1'b0);
    check("sw req", 32'(data_req_o), 32'd1);
    check("sw we", 32'(data_we_o), 32'd1);
    check("sw wb", 32'(wb_en_o), 32'd0);
    idle();
    check("sw rdy", 32'(instr_ready_o), 32'd1);
    check("sw exv", 32'(ex_valid_o), 32'd0);
    check("sw wb2", 32'(wb_en_o), 32'd0);

    // BEQ taken with ADD waiting: flush, ADD dropped
    cyc(1'b1, OP_BEQ, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
    check("beq flush", 32'(flush_o), 32'd1);
    check("beq rdy", 32'(instr_ready_o), 32'd0);
    check("beq wb", 32'(wb_en_o), 32'd0);
    cyc(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    check("flush exv", 32'(ex_valid_o), 32'd0);
    check("flush once", 32'(flush_o), 32'd0);

    // BNE not taken: ADD issues; taken on a non-branch does not flush
    cyc(1'b1, OP_BNE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b0);
    check("bne nflush", 32'(flush_o), 32'd0);
    check("bne inv", 32'(ex_ctrl_o.brn_inv), 32'd1);
    cyc(1'b0, OP_ADD, 1'b0, 1'b0, 1'b1);
    check("add nflush", 32'(flush_o), 32'd0);
    check("add issued", 32'(ex_valid_o), 32'd1);

    // JAL taken flushes too
    cyc(1'b1, OP_JAL, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1);
    check("jal flush", 32'(flush_o), 32'd1);
    check("jal wb", 32'(wb_en_o), 32'd1);

    // Unrecognised op
    cyc(1'b1, OP_INVALID, 1'b0, 1'b0, 1'b0);
    idle();
    check("inv ill", 32'(illegal_instr_o), 32'd1);
    check("inv exv", 32'(ex_valid_o), 32'd0);
    check("inv rdy", 32'(instr_ready_o), 32'd1);
    idle();
    check("inv once", 32'(illegal_instr_o), 32'd0);

    // Reset in the middle of a load
    cyc(1'b1, OP_LW, 1'b0, 1'b0, 1'b0);
    idle();
    check("lwr req", 32'(data_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("lwr req0", 32'(data_req_o), 32'd0);
    check("lwr exv0", 32'(ex_valid_o), 32'd0);
    check("lwr rdy", 32'(instr_ready_o), 32'd1);
    cyc(1'b0, OP_ADD, 1'b0, 1'b1, 1'b0);
    rst_i = 1'b0;
    #1;
    check("lwr wb", 32'(wb_en_o), 32'd0);

`ifdef RISCV_M_CORE_EN
    run_div("div", 32);
    idle();
    check("div rdy", 32'(instr_ready_o), 32'd1);
    check("div exv", 32'(ex_valid_o), 32'd0);
    check("div wb", 32'(wb_en_o), 32'd0);
    // counter holds 10 in the 23rd busy cycle
    run_div("divr", 23);
    rst_i = 1'b1;
    #1;
    check("divr rdy", 32'(instr_ready_o), 32'd1);
    check("divr exv", 32'(ex_valid_o), 32'd0);
    check("divr start", 32'(mdu_start_o), 32'd0);
    check("divr wb", 32'(wb_en_o), 32'd0);
    check("divr ctrl", 32'(ex_ctrl_o), 32'd0);
    idle();
    rst_i = 1'b0;
    #1;
    check("divr wb2", 32'(wb_en_o), 32'd0);
    run_div("div2", 32);
    idle();
    check("div2 rdy", 32'(instr_ready_o), 32'd1);
`else
    cyc(1'b1, OP_MUL, 1'b0, 1'b0, 1'b0);
    idle();
    check("mul ill", 32'(illegal_instr_o), 32'd1);
    check("mul exv", 32'(ex_valid_o), 32'd0);
    check("mul rdy", 32'(instr_ready_o), 32'd1);
    check("mul start", 32'(mdu_start_o), 32'd0);
    check("mul wb", 32'(wb_en_o), 32'd0);
    idle();
    check("mul once", 32'(illegal_instr_o), 32'd0);
    check("mul rdy2", 32'(instr_ready_o), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
